// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CHK,
    RUN,
    HALTED,
    ERR
  } state_e;

  localparam logic [15:0] HALT_INSTR = 16'h5000;
  localparam int unsigned MAX_WORDS  = 128;

endpackage

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// holds the processor in reset until a verified image is present.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  output logic              In_Ready,
  input  logic              Halt,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [DATA_W-1:0] IM_Data,
  output logic              Proc_Reset,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        WordCount
);

  state_e              state_q;
  logic [7:0]          len_q;
  logic [7:0]          hi_q;
  logic [7:0]          acc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                xfer;

  always_comb begin
    In_Ready = 1'b0;
    unique case (state_q)
      LEN, HI, LO, CHK: In_Ready = 1'b1;
      default:          In_Ready = 1'b0;
    endcase
  end

  assign xfer = In_Valid && In_Ready;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      hi_q       <= 8'd0;
      acc_q      <= 8'd0;
      addr_q     <= '0;
      IM_Wr      <= 1'b0;
      IM_Addr    <= '0;
      IM_Data    <= '0;
      Proc_Reset <= 1'b1;
      Done       <= 1'b0;
      Error      <= 1'b0;
      WordCount  <= 8'd0;
    end else begin
      IM_Wr <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= LEN;

        LEN: begin
          if (xfer) begin
            // Done from a previous run is only cleared once a new image starts.
            Done <= 1'b0;
            if (In_Data == 8'd0 || 32'(In_Data) > MAX_WORDS) begin
              state_q <= ERR;
              Error   <= 1'b1;
            end else begin
              len_q     <= In_Data;
              acc_q     <= 8'd0;
              WordCount <= 8'd0;
              addr_q    <= '0;
              state_q   <= HI;
            end
          end
        end

        HI: begin
          if (xfer) begin
            hi_q    <= In_Data;
            acc_q   <= acc_q ^ In_Data;
            state_q <= LO;
          end
        end

        LO: begin
          if (xfer) begin
            acc_q     <= acc_q ^ In_Data;
            IM_Wr     <= 1'b1;
            IM_Addr   <= addr_q;
            IM_Data   <= DATA_W'({hi_q, In_Data});
            addr_q    <= addr_q + ADDR_W'(1);
            WordCount <= WordCount + 8'd1;
            state_q   <= (WordCount + 8'd1 == len_q) ? CHK : HI;
          end
        end

        CHK: begin
          if (xfer) begin
            if (In_Data == acc_q) begin
              state_q    <= RUN;
              Proc_Reset <= 1'b0;
            end else begin
              state_q <= ERR;
              Error   <= 1'b1;
            end
          end
        end

        RUN: begin
          if (Halt) begin
            state_q    <= HALTED;
            Proc_Reset <= 1'b1;
            Done       <= 1'b1;
          end
        end

        HALTED: state_q <= LEN;

        ERR: state_q <= ERR;

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table plus write scoreboard.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              In_Valid = 1'b0;
  logic [7:0]        In_Data = 8'h00;
  logic              In_Ready;
  logic              Halt = 1'b0;
  logic              IM_Wr;
  logic [ADDR_W-1:0] IM_Addr;
  logic [DATA_W-1:0] IM_Data;
  logic              Proc_Reset;
  logic              Done;
  logic              Error;
  logic [7:0]        WordCount;

  program_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Data   (In_Data),
    .In_Ready  (In_Ready),
    .Halt      (Halt),
    .IM_Wr     (IM_Wr),
    .IM_Addr   (IM_Addr),
    .IM_Data   (IM_Data),
    .Proc_Reset(Proc_Reset),
    .Done      (Done),
    .Error     (Error),
    .WordCount (WordCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  len;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  chk;
    bit          gap;
    int          kind;  // 0: runs, 1: checksum error, 2: length error
  } vec_t;

  wr_t         sb[$];
  logic [15:0] words[$];
  int          compared = 0;
  int          mismatched = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Every write strobe must match the oldest expected write.
  always @(negedge Clk) begin : monitor
    wr_t e;
    if (IM_Wr === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 IM_Addr, IM_Data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(IM_Addr), 32'(e.addr));
        check("wr_data", 32'(IM_Data), 32'(e.data));
      end
    end
  end

  task automatic do_reset();
    Reset    = 1'b0;
    In_Valid = 1'b0;
    Halt     = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_in_ready", 32'(In_Ready), 32'd0);
    check("rst_im_wr", 32'(IM_Wr), 32'd0);
    check("rst_im_addr", 32'(IM_Addr), 32'd0);
    check("rst_im_data", 32'(IM_Data), 32'd0);
    check("rst_proc_reset", 32'(Proc_Reset), 32'd1);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_wordcount", 32'(WordCount), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("first_ready", 32'(In_Ready), 32'd1);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit done = 1'b0;
    if (gap) begin
      In_Valid = 1'b0;
      @(negedge Clk);
    end
    In_Valid = 1'b1;
    In_Data  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (In_Ready) begin
        @(posedge Clk);
        done = 1'b1;
      end
      @(negedge Clk);
    end
    In_Valid = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL byte_timeout: got In_Ready 0 for 20 cycles, required acceptance of %0h", b);
    end
  endtask

  task automatic send_words(input bit gap, output logic [7:0] x);
    wr_t w;
    x = 8'h00;
    for (int k = 0; k < words.size(); k++) begin
      w.addr = ADDR_W'(k);
      w.data = words[k];
      sb.push_back(w);
      send_byte(words[k][15:8], gap);
      send_byte(words[k][7:0], gap);
      x = x ^ words[k][15:8] ^ words[k][7:0];
    end
  endtask

  task automatic halt_and_check();
    Halt = 1'b1;
    @(negedge Clk);
    Halt = 1'b0;
    check("halt_done", 32'(Done), 32'd1);
    check("halt_proc_reset", 32'(Proc_Reset), 32'd1);
    @(negedge Clk);
    check("rearm_ready", 32'(In_Ready), 32'd1);
    check("rearm_done", 32'(Done), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t       vecs[6];
    logic [7:0] x;

    vecs[0] = '{len: 8'd2,   w0: 16'hA123, w1: HALT_INSTR, chk: 8'hD2, gap: 1'b0, kind: 0};
    vecs[1] = '{len: 8'd2,   w0: 16'hA123, w1: HALT_INSTR, chk: 8'h00, gap: 1'b0, kind: 1};
    vecs[2] = '{len: 8'd0,   w0: 16'h0000, w1: 16'h0000,   chk: 8'h00, gap: 1'b0, kind: 2};
    vecs[3] = '{len: 8'd129, w0: 16'h0000, w1: 16'h0000,   chk: 8'h00, gap: 1'b0, kind: 2};
    vecs[4] = '{len: 8'd2,   w0: 16'hA123, w1: HALT_INSTR, chk: 8'hD2, gap: 1'b1, kind: 0};
    vecs[5] = '{len: 8'd1,   w0: 16'h1234, w1: 16'h0000,   chk: 8'h26, gap: 1'b0, kind: 0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      words.delete();
      send_byte(vecs[v].len, vecs[v].gap);
      if (vecs[v].kind == 2) begin
        check("len_err_error", 32'(Error), 32'd1);
        check("len_err_proc_reset", 32'(Proc_Reset), 32'd1);
        check("len_err_ready", 32'(In_Ready), 32'd0);
        In_Valid = 1'b1;
        In_Data  = 8'h5A;
        Halt     = 1'b1;
        repeat (4) @(negedge Clk);
        In_Valid = 1'b0;
        Halt     = 1'b0;
        check("len_err_stuck_ready", 32'(In_Ready), 32'd0);
        check("len_err_halt_ignored", 32'(Done), 32'd0);
      end else begin
        words.push_back(vecs[v].w0);
        if (vecs[v].len > 8'd1) words.push_back(vecs[v].w1);
        send_words(vecs[v].gap, x);
        check("pre_chk_proc_reset", 32'(Proc_Reset), 32'd1);
        check("pre_chk_wordcount", 32'(WordCount), 32'(vecs[v].len));
        send_byte(vecs[v].chk, vecs[v].gap);
        if (vecs[v].kind == 0) begin
          check("run_proc_reset", 32'(Proc_Reset), 32'd0);
          check("run_error", 32'(Error), 32'd0);
          check("run_ready", 32'(In_Ready), 32'd0);
          halt_and_check();
        end else begin
          check("chk_err_error", 32'(Error), 32'd1);
          check("chk_err_proc_reset", 32'(Proc_Reset), 32'd1);
          check("chk_err_ready", 32'(In_Ready), 32'd0);
          In_Valid = 1'b1;
          In_Data  = 8'hA5;
          repeat (4) @(negedge Clk);
          In_Valid = 1'b0;
          check("chk_err_stuck_ready", 32'(In_Ready), 32'd0);
          check("chk_err_stuck_error", 32'(Error), 32'd1);
          check("chk_err_wordcount", 32'(WordCount), 32'(vecs[v].len));
        end
      end
    end

    // Reload after halt: the last vector left the loader re-armed with Done set.
    words.delete();
    words.push_back(HALT_INSTR);
    send_byte(8'd1, 1'b0);
    check("reload_done_clear", 32'(Done), 32'd0);
    send_words(1'b0, x);
    send_byte(8'h50, 1'b0);
    check("reload_proc_reset", 32'(Proc_Reset), 32'd0);
    check("reload_error", 32'(Error), 32'd0);
    halt_and_check();

    // Reset mid-frame, then a fresh nominal frame must write from address 0.
    do_reset();
    words.delete();
    words.push_back(16'hA123);
    send_byte(8'd2, 1'b0);
    send_words(1'b0, x);
    send_byte(8'h50, 1'b0);
    do_reset();
    words.delete();
    words.push_back(16'hA123);
    words.push_back(HALT_INSTR);
    send_byte(8'd2, 1'b0);
    send_words(1'b0, x);
    send_byte(8'hD2, 1'b0);
    check("midrst_proc_reset", 32'(Proc_Reset), 32'd0);
    check("midrst_error", 32'(Error), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);

    // Maximum length image.
    do_reset();
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(16'(i * 16'h0203) ^ 16'h1100);
    send_byte(8'd128, 1'b0);
    send_words(1'b0, x);
    check("max_wordcount", 32'(WordCount), 32'd128);
    check("max_last_addr", 32'(IM_Addr), 32'h7F);
    send_byte(x, 1'b0);
    check("max_proc_reset", 32'(Proc_Reset), 32'd0);
    check("max_error", 32'(Error), 32'd0);

    repeat (3) @(negedge Clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the 16-bit programmable processor. It accepts a length-prefixed, checksummed byte stream and assembles 16-bit instruction words from it. It writes those words into instruction memory at addresses 0 upward and holds the processor in reset until a complete, verified image is loaded. After the processor fetches the halt instruction (16'h5000), the loader re-arms so a new image can be loaded.

## Interface
Parameters:
- ADDR_W, 7: instruction memory address width (matches the 7-bit PC).
- DATA_W, 16: instruction word width.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-low reset.
- In_Valid  in  1  byte-stream source has a byte.
- In_Data  in  8  stream byte.
- In_Ready  out  1  loader accepts a byte this cycle.
- Halt  in  1  processor has fetched 16'h5000 (IR_Out == 16'h5000).
- IM_Wr  out  1  instruction memory write strobe, one cycle per word.
- IM_Addr  out  ADDR_W  instruction memory write address.
- IM_Data  out  DATA_W  instruction word to write.
- Proc_Reset  out  1  active-high reset to the processor.
- Done  out  1  image ran to halt.
- Error  out  1  sticky load error.
- WordCount  out  8  number of words written in the current load.

## Operation
- Transfer: a byte is transferred when In_Valid && In_Ready on a rising Clk edge.
- In_Ready: decoded from the state register; high only in LEN, HI, LO and CHK.
- Frame format: LEN byte N (1..128 words), then N words sent high byte first, then a CHK byte.
- CHK rule: CHK equals the XOR of every byte after LEN.
- IDLE: entered on reset. Moves to LEN after one cycle.
- LEN:
  - On transfer with N=0 or N>128, go to ERR.
  - Otherwise latch N, clear the XOR accumulator, clear WordCount and the address counter, then go to HI.
- HI: on transfer, latch the high byte, XOR it into the accumulator, go to LO.
- LO: on transfer:
  - XOR the byte into the accumulator.
  - Register IM_Data = {hi, lo}, IM_Addr = address counter, and IM_Wr = 1 for one cycle.
  - Increment the address counter and WordCount.
  - If WordCount+1 == N, go to CHK; otherwise go to HI.
- CHK: on transfer, if the byte equals the accumulator go to RUN; otherwise go to ERR.
- RUN:
  - Proc_Reset = 0.
  - When Halt = 1, go to HALTED.
- HALTED:
  - Proc_Reset = 1 and Done = 1.
  - Next cycle go to LEN; Done stays set until the next LEN transfer.
- ERR:
  - Error = 1 and Proc_Reset = 1. In_Ready stays 0.
  - Exits only through Reset.
- Halt is ignored in every state except RUN.
- No writes occur outside LO transfers; IM_Addr never wraps, because N ≤ 128 is enforced.

## Timing
- Reset values (while Reset=0): state IDLE, In_Ready 0, IM_Wr 0, IM_Addr 0, IM_Data 0, Proc_Reset 1, Done 0, Error 0, WordCount 0.
- First In_Ready=1 is two cycles after Reset rises (IDLE, then LEN).
- Throughput is one byte per cycle at most.
- IM_Wr/IM_Addr/IM_Data are registered: valid the cycle after the LO transfer, and IM_Wr is high for exactly that one cycle.
- Proc_Reset falls the cycle after the CHK transfer, and rises the cycle after Halt is sampled high in RUN.
- In_Valid may drop between bytes without loss; no byte is accepted while In_Ready=0.
- Reset during any state (including mid-frame or RUN) aborts immediately. A partially written memory image is left as-is, and Proc_Reset is reasserted in the same edge.

## Structure
- Shared package (loader_pkg):
  - state enum: IDLE, LEN, HI, LO, CHK, RUN, HALTED, ERR.
  - HALT_INSTR = 16'h5000.
  - MAX_WORDS = 128.
- Single module. No sub-module needed: the byte-to-word assembler is a few registers inside the FSM.
- In the processor top, IM_* drive the instruction memory write port, and Proc_Reset combines (OR) with the system reset into the processor Reset.

## Test plan
- Nominal load: N=2, words 16'hA123 and 16'h5000, CHK = A1^23^50^00 = 16'hD2.
  - Expect two IM_Wr pulses: (addr 0, A123) and (addr 1, 5000).
  - Expect Proc_Reset to fall the cycle after CHK.
  - Raising Halt then gives Done=1 and Proc_Reset=1.
- Bad checksum: same frame with CHK=16'h00 → Error=1, Proc_Reset stays 1, In_Ready=0, and further bytes are not accepted.
- Length bounds:
  - N=0 → ERR.
  - N=129 → ERR.
  - N=128 → 128 writes, last at IM_Addr=16'h7F, WordCount=128.
- Backpressure gaps: In_Valid toggled every other cycle through the nominal frame → identical writes and final state, with no extra IM_Wr.
- Reset mid-frame: Reset driven low after the HI byte of word 1, then a fresh nominal frame → writes restart at addr 0, and Error/Done are 0.
- Reload after halt: after Done, send a second frame N=1, word 16'h5000, CHK=16'h50 → write at addr 0, Done clears on the LEN transfer, RUN is re-entered.
